// File: rtl/fluorescence_gate_sequencer.sv
// Lock-in photon-counting sequencer. The light source alternates between ON and
// OFF windows, with an optional settle gap after each toggle. Synchronised PMT
// edges are accumulated per window, and the background-corrected net count is
// published at the end.
module fluorescence_gate_sequencer #(
   parameter int COUNT_W = 32,
   parameter int TIME_W  = 32,
   parameter int PER_W   = 16
) (
   input  logic               clock_in,
   input  logic               reset,
   input  logic               PMT_in,
   input  logic               start,
   input  logic               abort,
   input  logic [TIME_W-1:0]  on_cycles,
   input  logic [TIME_W-1:0]  off_cycles,
   input  logic [TIME_W-1:0]  settle_cycles,
   input  logic [PER_W-1:0]   n_periods,
   output logic               light_source_pin,
   output logic               busy,
   output logic               done,
   output logic               result_valid,
   output logic               overflow,
   output logic [COUNT_W-1:0] add_count,
   output logic [COUNT_W-1:0] subtract_count,
   output logic [COUNT_W:0]   net_count
);

   typedef enum logic [2:0] {
      IDLE, ON_SETTLE, ON_COUNT, OFF_SETTLE, OFF_COUNT, FINISH
   } state_t;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   state_t              state, state_next;
   logic                sync1, sync2, sync3, edge_pulse;
   logic [TIME_W-1:0]   on_last, off_last, settle_len, timer, timer_val;
   logic [PER_W-1:0]    n_last, period_cnt;
   logic                load_timer, start_run, period_inc, finish, light_next;
   logic                count_add, count_sub;
   logic [TIME_W-1:0]   on_last_in, off_last_in;

   // Window lengths are stored as "last index" so that a zero length behaves as one cycle
   assign on_last_in  = (on_cycles  == '0) ? '0 : on_cycles  - TIME_W'(1);
   assign off_last_in = (off_cycles == '0) ? '0 : off_cycles - TIME_W'(1);

   assign busy      = (state != IDLE);
   assign count_add = edge_pulse && (state == ON_COUNT)  && !abort;
   assign count_sub = edge_pulse && (state == OFF_COUNT) && !abort;

   // Two-flop synchroniser followed by a registered rising-edge detector
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync3      <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync1      <= PMT_in;
         sync2      <= sync1;
         sync3      <= sync2;
         edge_pulse <= sync2 & ~sync3;
      end
   end

   // State register
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and control strobes; an abort overrides every transition
   always_comb begin
      state_next = state;
      load_timer = 1'b0;
      timer_val  = '0;
      start_run  = 1'b0;
      period_inc = 1'b0;
      finish     = 1'b0;
      light_next = light_source_pin;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               start_run  = 1'b1;
               light_next = 1'b1;
               load_timer = 1'b1;
               if (settle_cycles == '0) begin
                  state_next = ON_COUNT;
                  timer_val  = on_last_in;
               end else begin
                  state_next = ON_SETTLE;
                  timer_val  = settle_cycles - TIME_W'(1);
               end
            end
         end
         ON_SETTLE: begin
            if (timer == '0) begin
               state_next = ON_COUNT;
               load_timer = 1'b1;
               timer_val  = on_last;
            end
         end
         ON_COUNT: begin
            if (timer == '0) begin
               light_next = 1'b0;
               load_timer = 1'b1;
               if (settle_len == '0) begin
                  state_next = OFF_COUNT;
                  timer_val  = off_last;
               end else begin
                  state_next = OFF_SETTLE;
                  timer_val  = settle_len - TIME_W'(1);
               end
            end
         end
         OFF_SETTLE: begin
            if (timer == '0) begin
               state_next = OFF_COUNT;
               load_timer = 1'b1;
               timer_val  = off_last;
            end
         end
         OFF_COUNT: begin
            if (timer == '0) begin
               period_inc = 1'b1;
               if (period_cnt == n_last) begin
                  state_next = FINISH;
               end else begin
                  light_next = 1'b1;
                  load_timer = 1'b1;
                  if (settle_len == '0) begin
                     state_next = ON_COUNT;
                     timer_val  = on_last;
                  end else begin
                     state_next = ON_SETTLE;
                     timer_val  = settle_len - TIME_W'(1);
                  end
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
            finish     = 1'b1;
            light_next = 1'b0;
         end
         default: state_next = IDLE;
      endcase
      if (abort && state != IDLE) begin
         state_next = IDLE;
         light_next = 1'b0;
         load_timer = 1'b0;
         period_inc = 1'b0;
         finish     = 1'b0;
      end
   end

   // Window timer counts down to zero; zero marks the last cycle of the current state
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset)          timer <= '0;
      else if (load_timer) timer <= timer_val;
      else if (timer != '0) timer <= timer - TIME_W'(1);
   end

   // Configuration latch, saturating accumulators, period counter and result publication
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         on_last          <= '0;
         off_last         <= '0;
         settle_len       <= '0;
         n_last           <= '0;
         period_cnt       <= '0;
         add_count        <= '0;
         subtract_count   <= '0;
         net_count        <= '0;
         overflow         <= 1'b0;
         result_valid     <= 1'b0;
         done             <= 1'b0;
         light_source_pin <= 1'b0;
      end else begin
         done             <= 1'b0;
         light_source_pin <= light_next;
         if (start_run) begin
            on_last        <= on_last_in;
            off_last       <= off_last_in;
            settle_len     <= settle_cycles;
            n_last         <= (n_periods == '0) ? '0 : n_periods - PER_W'(1);
            period_cnt     <= '0;
            add_count      <= '0;
            subtract_count <= '0;
            overflow       <= 1'b0;
            result_valid   <= 1'b0;
         end else begin
            if (count_add) begin
               if (add_count == COUNT_MAX) overflow <= 1'b1;
               else                        add_count <= add_count + COUNT_W'(1);
            end
            if (count_sub) begin
               if (subtract_count == COUNT_MAX) overflow <= 1'b1;
               else                             subtract_count <= subtract_count + COUNT_W'(1);
            end
            if (period_inc) period_cnt <= period_cnt + PER_W'(1);
            if (finish) begin
               net_count    <= {1'b0, add_count} - {1'b0, subtract_count};
               result_valid <= 1'b1;
               done         <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fluorescence_gate_sequencer.sv
// Self-checking bench for fluorescence_gate_sequencer: directed scenarios plus
// randomised measurements compared against a window-arithmetic reference model.
module tb_fluorescence_gate_sequencer;

   localparam int CW   = 4;
   localparam int TW   = 16;
   localparam int PW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock_in = 1'b0;
   logic          reset;
   logic          PMT_in;
   logic          start;
   logic          abort;
   logic [TW-1:0] on_cycles, off_cycles, settle_cycles;
   logic [PW-1:0] n_periods;
   logic          light_source_pin, busy, done, result_valid, overflow;
   logic [CW-1:0] add_count, subtract_count;
   logic [CW:0]   net_count;

   int checks = 0;
   int errors = 0;
   bit pulse_mark [0:2047];

   fluorescence_gate_sequencer #(.COUNT_W(CW), .TIME_W(TW), .PER_W(PW)) dut (
      .clock_in(clock_in), .reset(reset), .PMT_in(PMT_in), .start(start), .abort(abort),
      .on_cycles(on_cycles), .off_cycles(off_cycles), .settle_cycles(settle_cycles),
      .n_periods(n_periods), .light_source_pin(light_source_pin), .busy(busy),
      .done(done), .result_valid(result_valid), .overflow(overflow),
      .add_count(add_count), .subtract_count(subtract_count), .net_count(net_count)
   );

   // Free-running clock
   always #5 clock_in = ~clock_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_pulses();
      for (int i = 0; i < 2048; i++) pulse_mark[i] = 1'b0;
   endtask

   // Drives one measurement; pulse_mark[j] raises PMT_in for two cycles starting in cycle j
   // (cycle 0 is the first cycle after start is accepted). The model classifies each pulse
   // by the cycle its synchronised edge reaches the sequencer (j+3) within the period.
   task automatic run_meas(input string tag, input int on, input int off, input int s,
                           input int n, input int abort_at, input int glitch_at);
      int on_e, off_e, n_e, plen, total, last;
      int a_raw, s_raw, light_e, tog_e, p, k;
      int light_obs, tog_obs, busy_obs, done_obs;
      bit prev_e, lc, prev_obs;
      logic [CW-1:0] add_e, sub_e;
      logic [CW:0]   net_e;
      on_e  = (on  == 0) ? 1 : on;
      off_e = (off == 0) ? 1 : off;
      n_e   = (n   == 0) ? 1 : n;
      plen  = 2 * s + on_e + off_e;
      total = n_e * plen;
      last  = (abort_at >= 0) ? abort_at : total;

      a_raw = 0; s_raw = 0; light_e = 0; tog_e = 0; prev_e = 1'b0;
      for (int j = 0; j <= last + 3; j++) begin
         k = j + 3;
         if (pulse_mark[j] && k < last) begin
            p = k % plen;
            if (p >= s && p < s + on_e) a_raw++;
            else if (p >= 2 * s + on_e) s_raw++;
         end
      end
      for (int c = 0; c <= last + 3; c++) begin
         lc = (c <= last) && (c < total) && ((c % plen) < s + on_e);
         if (lc) light_e++;
         if (lc != prev_e) tog_e++;
         prev_e = lc;
      end
      add_e = (a_raw > CMAX) ? CW'(CMAX) : CW'(a_raw);
      sub_e = (s_raw > CMAX) ? CW'(CMAX) : CW'(s_raw);
      net_e = {1'b0, add_e} - {1'b0, sub_e};

      @(negedge clock_in);
      on_cycles = TW'(on); off_cycles = TW'(off); settle_cycles = TW'(s); n_periods = PW'(n);
      start = 1'b1; abort = 1'b0;
      prev_obs = light_source_pin;
      @(negedge clock_in);
      start = 1'b0;
      light_obs = 0; tog_obs = 0; busy_obs = 0; done_obs = 0;
      for (int j = 0; j <= last + 3; j++) begin
         if (light_source_pin) light_obs++;
         if (light_source_pin != prev_obs) tog_obs++;
         prev_obs = light_source_pin;
         if (busy) busy_obs++;
         if (done) done_obs++;
         if (abort_at >= 0 && j == abort_at + 1) begin
            check({tag, "_abort_light"}, 32'(light_source_pin), 32'd0);
            check({tag, "_abort_busy"}, 32'(busy), 32'd0);
         end
         PMT_in = pulse_mark[j] || (j > 0 && pulse_mark[j-1]);
         abort  = (j == abort_at);
         if (j == glitch_at) begin
            start = 1'b1; on_cycles = TW'(3); n_periods = PW'(5);
         end else begin
            start = 1'b0;
         end
         @(negedge clock_in);
      end
      PMT_in = 1'b0; abort = 1'b0; start = 1'b0;
      check({tag, "_add"}, 32'(add_count), 32'(add_e));
      check({tag, "_sub"}, 32'(subtract_count), 32'(sub_e));
      check({tag, "_ovf"}, 32'(overflow), 32'((a_raw > CMAX) || (s_raw > CMAX)));
      check({tag, "_valid"}, 32'(result_valid), (abort_at >= 0) ? 32'd0 : 32'd1);
      check({tag, "_done_cnt"}, 32'(done_obs), (abort_at >= 0) ? 32'd0 : 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy_obs), 32'(last + 1));
      check({tag, "_light_cycles"}, 32'(light_obs), 32'(light_e));
      check({tag, "_light_toggles"}, 32'(tog_obs), 32'(tog_e));
      if (abort_at < 0) check({tag, "_net"}, 32'(net_count), 32'(net_e));
      clear_pulses();
      repeat (5) @(negedge clock_in);
   endtask

   // Directed scenarios followed by randomised measurements
   initial begin
      int on_r, off_r, s_r, n_r, tot_r, jj;
      reset = 1'b0; PMT_in = 1'b0; start = 1'b0; abort = 1'b0;
      on_cycles = '0; off_cycles = '0; settle_cycles = '0; n_periods = '0;
      clear_pulses();
      repeat (2) @(negedge clock_in);
      check("rst_light", 32'(light_source_pin), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_counts", {16'(add_count), 16'(subtract_count)}, 32'd0);
      check("rst_net", 32'(net_count), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock_in);

      // Basic: edges on cycles 3, 7, 11 (last ON cycle) and 15 (OFF); start while busy ignored
      pulse_mark[0] = 1; pulse_mark[4] = 1; pulse_mark[8] = 1; pulse_mark[12] = 1;
      run_meas("basic", 10, 10, 2, 1, -1, 6);

      // Settle exclusion: edges land on the last ON_SETTLE cycle and inside OFF_SETTLE
      pulse_mark[1] = 1; pulse_mark[9] = 1;
      run_meas("settle", 6, 6, 5, 1, -1, -1);

      // Multi-period, negative result
      for (int m = 0; m < 3; m++) begin
         pulse_mark[16*m+1] = 1; pulse_mark[16*m+7] = 1; pulse_mark[16*m+11] = 1;
      end
      run_meas("multi", 8, 8, 0, 3, -1, -1);

      // Saturation, then a clean restart clears it
      for (int i = 0; i < 20; i++) pulse_mark[4*i] = 1;
      run_meas("sat", 100, 5, 0, 1, -1, -1);
      run_meas("sat_clear", 100, 5, 0, 1, -1, -1);

      // Abort in the fourth ON_COUNT cycle, with one edge already counted
      pulse_mark[0] = 1;
      run_meas("abort", 10, 10, 2, 1, 5, -1);

      // start and abort together in IDLE: nothing starts
      @(negedge clock_in);
      start = 1'b1; abort = 1'b1; on_cycles = TW'(5);
      @(negedge clock_in);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_light", 32'(light_source_pin), 32'd0);
      repeat (2) @(negedge clock_in);

      // Reset in the middle of OFF_COUNT after one ON edge was counted
      on_cycles = TW'(20); off_cycles = TW'(20); settle_cycles = TW'(2); n_periods = PW'(1);
      start = 1'b1;
      @(negedge clock_in);
      start = 1'b0;
      for (int j = 0; j < 29; j++) begin
         PMT_in = (j == 3 || j == 4);
         @(negedge clock_in);
      end
      check("pre_rst_add", 32'(add_count), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_light", 32'(light_source_pin), 32'd0);
      check("midrst_add", 32'(add_count), 32'd0);
      check("midrst_valid_ovf", {31'd0, result_valid | overflow}, 32'd0);
      @(negedge clock_in);
      reset = 1'b1;
      repeat (2) @(negedge clock_in);

      // Zero configuration behaves as single-cycle windows and one period
      run_meas("zero_cfg", 0, 0, 0, 0, -1, -1);

      // Randomised measurements
      for (int r = 0; r < 6; r++) begin
         on_r  = $urandom_range(0, 12);
         off_r = $urandom_range(0, 12);
         s_r   = $urandom_range(0, 4);
         n_r   = $urandom_range(0, 3);
         tot_r = ((n_r == 0) ? 1 : n_r) *
                 (2 * s_r + ((on_r == 0) ? 1 : on_r) + ((off_r == 0) ? 1 : off_r));
         jj = 0;
         while (jj < tot_r) begin
            if ($urandom_range(0, 2) == 0) begin
               pulse_mark[jj] = 1;
               jj += 4 + $urandom_range(0, 3);
            end else begin
               jj++;
            end
         end
         run_meas($sformatf("rand%0d", r), on_r, off_r, s_r, n_r, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
